// File: rtl/apb_reg_bank_pkg.sv
// Shared definitions for the APB register bank and its transfer controller.
// Holds the controller FSM encoding and the APB word-address shift.
package apb_reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

  localparam int APB_WORD_SHIFT = 2;

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB slave transfer sequencer: setup capture, programmable wait states, one-cycle pready.
// Ports: clk/rst_n, setup_i/psel_i in; capture_o (setup accepted), commit_o (edge entering DONE), pready_o.
module apb_wait_ctrl
  import apb_reg_bank_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic setup_i,
  input  logic psel_i,
  output logic capture_o,
  output logic commit_o,
  output logic pready_o
);

  localparam logic [3:0] WS_INIT =
    4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  apb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_o = 1'b0;
    commit_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (setup_i) begin
          capture_o = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d  = ST_DONE;
            commit_o = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      ST_WAIT: begin
        // Master dropping psel mid-transfer abandons it silently.
        if (!psel_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d  = ST_DONE;
          commit_o = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign pready_o = (state_q == ST_DONE);

endmodule

// File: rtl/apb_reg_bank.sv
// Generic APB control/status block: NUM_REGS 32-bit R/W or read-only registers.
// Ports: APB slave (pclk..pslverr), reg_out/reg_in fabric bus, wr_pulse per-register write strobes.
module apb_reg_bank
  import apb_reg_bank_pkg::*;
#(
  parameter int              NUM_REGS    = 4,
  parameter int              ADDR_WIDTH  = 8,
  parameter int              WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [31:0]     RESET_VAL   = 32'h0,
  parameter bit              PRIV_ONLY   = 1'b0
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic [ADDR_WIDTH-1:0]    paddr,
  input  logic                     pwrite,
  input  logic [31:0]              pwdata,
  input  logic [3:0]               pstrb,
  input  logic [2:0]               pprot,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [32*NUM_REGS-1:0]   reg_out,
  input  logic [32*NUM_REGS-1:0]   reg_in,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IW = ADDR_WIDTH - APB_WORD_SHIFT;

  logic          capture, commit;
  logic [IW-1:0] idx_in, idx_q, idx_c;
  logic          we_q, we_c;
  logic [31:0]   wdata_q, wdata_c;
  logic [3:0]    strb_q, strb_c;
  logic          err_in, err_q, err_c;
  logic          ro_in, range_err, wr_en;
  logic [31:0]   rd_val;
  logic [31:0]   prdata_q;
  logic          pslverr_q;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [NUM_REGS-1:0][31:0] rval;
  logic          unused_ok;

  assign unused_ok = ^{pprot[2:1], reg_in};

  apb_wait_ctrl #(
    .WAIT_STATES(WAIT_STATES)
  ) u_ctrl (
    .clk      (pclk),
    .rst_n    (preset_n),
    .setup_i  (psel & ~penable),
    .psel_i   (psel),
    .capture_o(capture),
    .commit_o (commit),
    .pready_o (pready)
  );

  assign idx_in = paddr[ADDR_WIDTH-1:APB_WORD_SHIFT];

  always_comb begin
    ro_in = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_in == IW'(i)) ro_in = RO_MASK[i];
    end
  end

  assign range_err = {1'b0, idx_in} >= (IW+1)'(NUM_REGS);
  assign err_in = range_err
                | (paddr[1:0] != 2'b00)
                | (pwrite & ro_in)
                | (PRIV_ONLY & ~pprot[0]);

  // Zero-wait transfers commit in the capture cycle, so bypass the latches.
  assign idx_c   = capture ? idx_in : idx_q;
  assign we_c    = capture ? pwrite : we_q;
  assign wdata_c = capture ? pwdata : wdata_q;
  assign strb_c  = capture ? pstrb  : strb_q;
  assign err_c   = capture ? err_in : err_q;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else if (capture) begin
      idx_q   <= idx_in;
      we_q    <= pwrite;
      wdata_q <= pwdata;
      strb_q  <= pstrb;
      err_q   <= err_in;
    end
  end

  assign wr_en = commit & we_c & ~err_c;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (RO_MASK[g]) begin : g_ro
      assign rval[g] = reg_in[32*g +: 32];
    end else begin : g_rw
      logic [31:0] val_q;
      always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
          val_q <= RESET_VAL;
        end else if (wr_en && idx_c == IW'(g)) begin
          for (int k = 0; k < 4; k++) begin
            if (strb_c[k]) val_q[8*k +: 8] <= wdata_c[8*k +: 8];
          end
        end
      end
      assign rval[g] = val_q;
    end
  end

  always_comb begin
    rd_val     = '0;
    wr_pulse_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_c == IW'(i)) begin
        rd_val        = rval[i];
        wr_pulse_d[i] = wr_en;
      end
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
      wr_pulse_q <= '0;
    end else begin
      pslverr_q  <= commit & err_c;
      wr_pulse_q <= wr_pulse_d;
      if (commit && !we_c) prdata_q <= err_c ? 32'h0 : rd_val;
    end
  end

  assign prdata   = prdata_q;
  assign pslverr  = pslverr_q;
  assign wr_pulse = wr_pulse_q;
  assign reg_out  = rval;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench for apb_reg_bank: zero-wait instance A, 3-wait RO/privileged instance B.
// Directed scenarios plus randomized traffic against an array-based reference model.
module tb_apb_reg_bank;

  logic         pclk = 1'b0;
  logic         preset_n = 1'b0;
  logic         psel_a = 1'b0, psel_b = 1'b0;
  logic         penable = 1'b0;
  logic [7:0]   paddr = '0;
  logic         pwrite = 1'b0;
  logic [31:0]  pwdata = '0;
  logic [3:0]   pstrb = '0;
  logic [2:0]   pprot = '0;
  logic [127:0] reg_in;
  logic [31:0]  prdata_a, prdata_b;
  logic         pready_a, pready_b, pslverr_a, pslverr_b;
  logic [127:0] reg_out_a, reg_out_b;
  logic [3:0]   wr_pulse_a, wr_pulse_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] mA [4];
  logic [31:0] mB [4];
  logic [31:0] lastA, lastB;

  always #5 pclk = ~pclk;

  apb_reg_bank #(
    .NUM_REGS(4), .ADDR_WIDTH(8), .WAIT_STATES(0),
    .RO_MASK(4'b0000), .RESET_VAL(32'h0), .PRIV_ONLY(1'b0)
  ) dut_a (
    .pclk(pclk), .preset_n(preset_n), .psel(psel_a), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata_a), .pready(pready_a),
    .pslverr(pslverr_a), .reg_out(reg_out_a), .reg_in(reg_in),
    .wr_pulse(wr_pulse_a)
  );

  apb_reg_bank #(
    .NUM_REGS(4), .ADDR_WIDTH(8), .WAIT_STATES(3),
    .RO_MASK(4'b0010), .RESET_VAL(32'h0), .PRIV_ONLY(1'b1)
  ) dut_b (
    .pclk(pclk), .preset_n(preset_n), .psel(psel_b), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pprot(pprot), .prdata(prdata_b), .pready(pready_b),
    .pslverr(pslverr_b), .reg_out(reg_out_b), .reg_in(reg_in),
    .wr_pulse(wr_pulse_b)
  );

  function automatic bit model_err(bit b, logic [7:0] a, bit wr,
                                   logic [2:0] pr);
    int idx = int'(a) / 4;
    return (idx >= 4) || (a % 4 != 0) ||
           (b && wr && idx == 1) || (b && !pr[0]);
  endfunction

  function automatic logic [127:0] exp_regs(bit b);
    logic [127:0] v;
    for (int i = 0; i < 4; i++) begin
      if (b && i == 1) v[32*i +: 32] = reg_in[63:32];
      else v[32*i +: 32] = b ? mB[i] : mA[i];
    end
    return v;
  endfunction

  // Applies one completed transfer to the model; returns what the DUT must show.
  task automatic model_apply(input bit b, input logic [7:0] a, input bit wr,
                             input logic [31:0] wd, input logic [3:0] st,
                             input logic [2:0] pr, output logic [31:0] erd,
                             output bit eerr, output logic [3:0] ewp);
    int idx = int'(a) / 4;
    logic [31:0] old;
    eerr = model_err(b, a, wr, pr);
    ewp  = '0;
    erd  = b ? lastB : lastA;
    if (wr && !eerr) begin
      old = b ? mB[idx] : mA[idx];
      for (int k = 0; k < 4; k++) if (st[k]) old[8*k +: 8] = wd[8*k +: 8];
      if (b) mB[idx] = old; else mA[idx] = old;
      ewp[idx] = 1'b1;
    end
    if (!wr) begin
      if (eerr) erd = 32'h0;
      else if (b && idx == 1) erd = reg_in[63:32];
      else erd = b ? mB[idx] : mA[idx];
      if (b) lastB = erd; else lastA = erd;
    end
  endtask

  task automatic xfer(input bit b, input logic [7:0] a, input bit wr,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic [2:0] pr, output logic [31:0] rd,
                      output bit se, output logic [3:0] wp,
                      output logic [127:0] ro, output int lat);
    @(negedge pclk);
    psel_a = !b; psel_b = b; penable = 1'b0;
    paddr = a; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr;
    @(negedge pclk);
    penable = 1'b1;
    lat = 0;
    while (!(b ? pready_b : pready_a) && lat < 40) begin
      @(negedge pclk);
      lat++;
    end
    rd = b ? prdata_b : prdata_a;
    se = b ? pslverr_b : pslverr_a;
    wp = b ? wr_pulse_b : wr_pulse_a;
    ro = b ? reg_out_b : reg_out_a;
    psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin mA[i] = '0; mB[i] = '0; end
    lastA = '0; lastB = '0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    checks++;
    if (pready_a !== 1'b0 || pslverr_a !== 1'b0 || prdata_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_a: rdy=%b err=%b rd=%h want 0/0/0",
               pready_a, pslverr_a, prdata_a);
    end
    checks++;
    if (reg_out_a !== exp_regs(1'b0) || wr_pulse_a !== 4'h0) begin
      errors++;
      $display("FAIL reset_a_regs: regs=%h wp=%b want %h/0000",
               reg_out_a, wr_pulse_a, exp_regs(1'b0));
    end
    // Load B then reset in the middle of a waited write.
    begin
      logic [31:0] rd; bit se; logic [3:0] wp; logic [127:0] ro; int lat;
      xfer(1'b1, 8'h0, 1'b1, 32'hCAFEF00D, 4'hF, 3'b001, rd, se, wp, ro, lat);
    end
    @(negedge pclk);
    psel_b = 1'b1; penable = 1'b0; paddr = 8'h0; pwrite = 1'b0; pprot = 3'b001;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (pready_b !== 1'b0 || pslverr_b !== 1'b0 || prdata_b !== 32'h0 ||
        reg_out_b !== exp_regs(1'b1)) begin
      errors++;
      $display("FAIL reset_mid_wait: rdy=%b err=%b rd=%h regs=%h want 0/0/0/%h",
               pready_b, pslverr_b, prdata_b, reg_out_b, exp_regs(1'b1));
    end
    psel_b = 1'b0; penable = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    repeat (2) @(negedge pclk);
    checks++;
    if (pready_b !== 1'b0 || reg_out_b !== exp_regs(1'b1)) begin
      errors++;
      $display("FAIL reset_release: rdy=%b regs=%h want 0/%h",
               pready_b, reg_out_b, exp_regs(1'b1));
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] rd, erd; bit se, ee; logic [3:0] wp, ewp;
    logic [127:0] ro; int lat;
    xfer(1'b0, 8'h4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, rd, se, wp, ro, lat);
    model_apply(1'b0, 8'h4, 1'b1, 32'hDEADBEEF, 4'hF, 3'b000, erd, ee, ewp);
    checks++;
    if (lat !== 0 || se !== 1'b0 || wp !== 4'b0010) begin
      errors++;
      $display("FAIL zero_wait: lat=%0d err=%b wp=%b want 0/0/0010",
               lat, se, wp);
    end
    checks++;
    if (ro[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL zero_wait_reg: got %h want deadbeef", ro[63:32]);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd, erd; bit se, ee; logic [3:0] wp, ewp;
    logic [127:0] ro; int lat;
    xfer(1'b0, 8'h0, 1'b1, 32'h11223344, 4'hF, 3'b000, rd, se, wp, ro, lat);
    model_apply(1'b0, 8'h0, 1'b1, 32'h11223344, 4'hF, 3'b000, erd, ee, ewp);
    xfer(1'b0, 8'h0, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b000, rd, se, wp, ro, lat);
    model_apply(1'b0, 8'h0, 1'b1, 32'hAABBCCDD, 4'b0101, 3'b000, erd, ee, ewp);
    xfer(1'b0, 8'h0, 1'b0, 32'h0, 4'h0, 3'b000, rd, se, wp, ro, lat);
    model_apply(1'b0, 8'h0, 1'b0, 32'h0, 4'h0, 3'b000, erd, ee, ewp);
    checks++;
    if (rd !== 32'h11BB33DD || se !== 1'b0) begin
      errors++;
      $display("FAIL byte_lanes: got %h err=%b want 11bb33dd/0", rd, se);
    end
    xfer(1'b0, 8'h0, 1'b1, 32'h99999999, 4'h0, 3'b000, rd, se, wp, ro, lat);
    model_apply(1'b0, 8'h0, 1'b1, 32'h99999999, 4'h0, 3'b000, erd, ee, ewp);
    checks++;
    if (wp !== 4'b0001 || ro[31:0] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strb_zero: wp=%b reg=%h want 0001/11bb33dd",
               wp, ro[31:0]);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, erd; bit se, ee; logic [3:0] wp, ewp;
    logic [127:0] ro; int lat;
    xfer(1'b1, 8'h8, 1'b1, 32'h0BADC0DE, 4'hF, 3'b001, rd, se, wp, ro, lat);
    model_apply(1'b1, 8'h8, 1'b1, 32'h0BADC0DE, 4'hF, 3'b001, erd, ee, ewp);
    checks++;
    if (lat !== 3 || wp !== 4'b0100) begin
      errors++;
      $display("FAIL wait_write: lat=%0d wp=%b want 3/0100", lat, wp);
    end
    xfer(1'b1, 8'h8, 1'b0, 32'h0, 4'h0, 3'b001, rd, se, wp, ro, lat);
    model_apply(1'b1, 8'h8, 1'b0, 32'h0, 4'h0, 3'b001, erd, ee, ewp);
    checks++;
    if (lat !== 3 || rd !== 32'h0BADC0DE || se !== 1'b0) begin
      errors++;
      $display("FAIL wait_read: lat=%0d rd=%h err=%b want 3/0badc0de/0",
               lat, rd, se);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; bit se, ee; logic [3:0] wp, ewp;
    logic [127:0] ro; int lat;
    xfer(1'b0, 8'h10, 1'b0, 32'h0, 4'h0, 3'b000, rd, se, wp, ro, lat);
    model_apply(1'b0, 8'h10, 1'b0, 32'h0, 4'h0, 3'b000, erd, ee, ewp);
    checks++;
    if (se !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL err_range: err=%b rd=%h want 1/0", se, rd);
    end
    xfer(1'b0, 8'h5, 1'b1, 32'h12345678, 4'hF, 3'b000, rd, se, wp, ro, lat);
    model_apply(1'b0, 8'h5, 1'b1, 32'h12345678, 4'hF, 3'b000, erd, ee, ewp);
    checks++;
    if (se !== 1'b1 || wp !== 4'h0 || ro !== exp_regs(1'b0)) begin
      errors++;
      $display("FAIL err_misalign: err=%b wp=%b want 1/0000", se, wp);
    end
    xfer(1'b1, 8'h4, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, rd, se, wp, ro, lat);
    model_apply(1'b1, 8'h4, 1'b1, 32'hFFFFFFFF, 4'hF, 3'b001, erd, ee, ewp);
    checks++;
    if (se !== 1'b1 || wp !== 4'h0) begin
      errors++;
      $display("FAIL err_ro_write: err=%b wp=%b want 1/0000", se, wp);
    end
    xfer(1'b1, 8'h4, 1'b0, 32'h0, 4'h0, 3'b001, rd, se, wp, ro, lat);
    model_apply(1'b1, 8'h4, 1'b0, 32'h0, 4'h0, 3'b001, erd, ee, ewp);
    checks++;
    if (se !== 1'b0 || rd !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL ro_read: err=%b rd=%h want 0/5a5a5a5a", se, rd);
    end
  endtask

  task automatic test_abort_priv();
    logic [31:0] rd, erd; bit se, ee; logic [3:0] wp, ewp;
    logic [127:0] ro; int lat;
    bit seen;
    @(negedge pclk);
    psel_b = 1'b1; penable = 1'b0; paddr = 8'hC; pwrite = 1'b1;
    pwdata = 32'h77777777; pstrb = 4'hF; pprot = 3'b001;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel_b = 1'b0; penable = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk);
      if (pready_b || wr_pulse_b != 4'h0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || reg_out_b !== exp_regs(1'b1)) begin
      errors++;
      $display("FAIL abort: pready/pulse seen=%b regs=%h want 0/%h",
               seen, reg_out_b, exp_regs(1'b1));
    end
    xfer(1'b1, 8'h0, 1'b1, 32'h13572468, 4'hF, 3'b000, rd, se, wp, ro, lat);
    model_apply(1'b1, 8'h0, 1'b1, 32'h13572468, 4'hF, 3'b000, erd, ee, ewp);
    checks++;
    if (se !== 1'b1 || wp !== 4'h0 || ro !== exp_regs(1'b1)) begin
      errors++;
      $display("FAIL priv: err=%b wp=%b regs=%h want 1/0000/%h",
               se, wp, ro, exp_regs(1'b1));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] erd; bit ee; logic [3:0] ewp;
    int lat;
    @(negedge pclk);
    psel_a = 1'b1; penable = 1'b0; paddr = 8'hC; pwrite = 1'b1;
    pwdata = 32'h600DF00D; pstrb = 4'hF; pprot = 3'b000;
    @(negedge pclk);
    penable = 1'b1;
    lat = 0;
    while (!pready_a && lat < 40) begin @(negedge pclk); lat++; end
    model_apply(1'b0, 8'hC, 1'b1, 32'h600DF00D, 4'hF, 3'b000, erd, ee, ewp);
    // Next setup is presented right away and held through the IDLE cycle.
    penable = 1'b0; paddr = 8'hC; pwrite = 1'b0;
    @(negedge pclk);
    checks++;
    if (pready_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: pready=%b want 0", pready_a);
    end
    @(negedge pclk);
    penable = 1'b1;
    lat = 0;
    while (!pready_a && lat < 40) begin @(negedge pclk); lat++; end
    model_apply(1'b0, 8'hC, 1'b0, 32'h0, 4'h0, 3'b000, erd, ee, ewp);
    checks++;
    if (lat !== 0 || prdata_a !== erd || pslverr_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_read: lat=%0d rd=%h err=%b want 0/%h/0",
               lat, prdata_a, pslverr_a, erd);
    end
    psel_a = 1'b0; penable = 1'b0;
  endtask

  task automatic test_random(input bit b);
    logic [31:0] rd, erd, wd; bit se, ee, wr; logic [3:0] wp, ewp, st;
    logic [127:0] ro; logic [7:0] a; logic [2:0] pr; int lat, bad;
    bad = 0;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom_range(0, 5) * 4);
      if ($urandom_range(0, 5) == 0) a = a + 8'($urandom_range(1, 3));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom);
      pr = 3'($urandom);
      if ($urandom_range(0, 3) != 0) pr[0] = 1'b1;
      xfer(b, a, wr, wd, st, pr, rd, se, wp, ro, lat);
      model_apply(b, a, wr, wd, st, pr, erd, ee, ewp);
      checks++;
      if (rd !== erd || se !== ee || wp !== ewp || ro !== exp_regs(b) ||
          lat !== (b ? 3 : 0)) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL rand_%s a=%h wr=%b: rd=%h err=%b wp=%b lat=%0d want %h/%b/%b/%0d",
                   b ? "b" : "a", a, wr, rd, se, wp, lat, erd, ee, ewp,
                   b ? 3 : 0);
      end
    end
  endtask

  initial begin
    reg_in = {$urandom, $urandom, 32'h5A5A5A5A, $urandom};
    test_reset();
    test_zero_wait();
    test_byte_lanes();
    test_wait_states();
    test_errors();
    test_abort_priv();
    test_back_to_back();
    test_random(1'b0);
    test_random(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
